frame_scheduler: RTL and testbench
==================================

// Module: frame_scheduler
// PURPOSE
//  Per-frame sequencer and pixel arbiter between the object drawers (platform, ball, bricks) and the 160x120 VGA adapter.
//  On each frame tick, visits every client in index order: erase pass at the old position, one-cycle update pulse, then draw pass.
//  Forwards only the active client's pixel stream to the adapter's single write port.
// PARAMETERS
//  NUM_CLIENTS   3        number of drawer clients, index 0 served first
//  FRAME_CYCLES  833333   clk cycles per frame (50 MHz / 60 Hz)
//  PASS_TIMEOUT  4096     max cycles a pass may last before it is aborted
//  ERASE_COLOUR  3'b000   colour forced onto the port during erase passes
// PORTS
//  clk        in   1             clock
//  resetn     in   1             synchronous active-low reset
//  go         in   1             level; 1 = frames are scheduled
//  cl_start   out  NUM_CLIENTS   one-cycle pass start per client (drives client draw)
//  cl_update  out  NUM_CLIENTS   one-cycle position-update pulse per client (drives client enable)
//  cl_erase   out  1             1 during the whole erase pass of the active client
//  cl_x       in   10*NUM_CLIENTS  packed client x; client i at [10*i+:10]
//  cl_y       in   10*NUM_CLIENTS  packed client y
//  cl_colour  in   3*NUM_CLIENTS   packed client colour
//  cl_wren    in   NUM_CLIENTS   client pixel write strobe
//  cl_done    in   NUM_CLIENTS   client pass-complete pulse
//  vga_x      out  8             pixel x to adapter
//  vga_y      out  7             pixel y to adapter
//  vga_colour out  3             pixel colour to adapter
//  vga_wren   out  1             pixel write strobe to adapter
//  frame_tick out  1             one-cycle pulse per frame
//  busy       out  1             1 whenever the FSM is not in IDLE
//  overrun    out  8             saturating count of dropped frame ticks
//  timeout_err out 1             sticky; set when any pass is aborted
// BEHAVIOUR
//  Reset: all outputs 0; tick counter 0; FSM in IDLE; client index 0.
//  Frame timer: counter runs 0..FRAME_CYCLES-1 and wraps. frame_tick=1 on the cycle the counter equals FRAME_CYCLES-1. Counter runs regardless of go.
//  FSM states:
//   IDLE   -> E_START when frame_tick & go; sets idx=0.
//   E_START: cl_start[idx]=1 and cl_erase=1 for one cycle -> E_WAIT.
//   E_WAIT: cl_erase=1; -> UPD on cl_done[idx] or on timeout.
//   UPD: cl_update[idx]=1 for one cycle -> D_START.
//   D_START: cl_start[idx]=1 -> D_WAIT.
//   D_WAIT: -> NEXT on cl_done[idx] or on timeout.
//   NEXT: if idx==NUM_CLIENTS-1 -> IDLE, otherwise idx+1 -> E_START.
//  cl_done is sampled only in E_WAIT and D_WAIT. done in the start cycle is ignored. done from a non-active client is ignored.
//  Pass timer: clears in each *_START state and increments in *_WAIT. Reaching PASS_TIMEOUT ends the pass and sets timeout_err (cleared only by reset).
//  Pixel path: vga_* are registered copies of the active client's signals, 1-cycle latency.
//   vga_wren = cl_wren[idx] only in the *_START and *_WAIT states, otherwise 0.
//   During an erase pass, vga_colour = ERASE_COLOUR.
//   Clipping: if client x>=160 or y>=120, vga_wren=0. vga_x/vga_y are the low 8/7 bits.
//  Overrun: a frame_tick that arrives while busy is dropped; overrun increments and saturates at 255.
//  go low mid-frame: the current frame completes; no new frame starts.
//  resetn low in any state: next cycle is IDLE with all outputs 0, even mid-pass.
// TESTING (bench: NUM_CLIENTS=2, FRAME_CYCLES=100, PASS_TIMEOUT=16)
//  1. go=1; client models return done 5 cycles after start -> per frame, in order:
//     cl_start[0] (erase), cl_update[0], cl_start[0], then the same for client 1; busy falls before the next tick.
//  2. Client 0 erase pass with wren=1, x=32, y=64, colour=3'b100 -> one cycle later vga_x=32, vga_y=64, vga_colour=000, vga_wren=1.
//     Draw pass with the same inputs -> vga_colour=100.
//  3. Client drives x=165, y=64 with wren=1 -> vga_wren stays 0. x=159, y=119 -> vga_wren=1.
//  4. Client 1 never asserts done -> its pass ends 16 cycles after start, timeout_err=1, FSM proceeds; timeout_err is still 1 after the next frame.
//  5. Clients hold done off for 150 cycles -> overrun=1 after the first dropped tick; after forcing 300 drops, overrun=255.
//  6. resetn pulsed low during D_WAIT -> next cycle busy=0, all vga_* and cl_* =0.
//     After release, the next frame starts cleanly at client 0; stray done pulses while in IDLE cause no transition.

Source files
------------

// File: rtl/frame_scheduler.sv
// frame_scheduler
// Per-frame sequencer and pixel arbiter between the object drawers and the
// 160x120 VGA adapter. On every frame tick each client is visited in index
// order: erase pass at its old position, a one-cycle update pulse, then a
// draw pass. Only the active client's pixel stream reaches the adapter.
// All control outputs are registered from the next-state value so that they
// line up exactly with the FSM state they describe.

module frame_scheduler #(
    parameter int         NUM_CLIENTS  = 3,
    parameter int         FRAME_CYCLES = 833333,
    parameter int         PASS_TIMEOUT = 4096,
    parameter logic [2:0] ERASE_COLOUR = 3'b000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      go,
    output logic [NUM_CLIENTS-1:0]    cl_start,
    output logic [NUM_CLIENTS-1:0]    cl_update,
    output logic                      cl_erase,
    input  logic [10*NUM_CLIENTS-1:0] cl_x,
    input  logic [10*NUM_CLIENTS-1:0] cl_y,
    input  logic [3*NUM_CLIENTS-1:0]  cl_colour,
    input  logic [NUM_CLIENTS-1:0]    cl_wren,
    input  logic [NUM_CLIENTS-1:0]    cl_done,
    output logic [7:0]                vga_x,
    output logic [6:0]                vga_y,
    output logic [2:0]                vga_colour,
    output logic                      vga_wren,
    output logic                      frame_tick,
    output logic                      busy,
    output logic [7:0]                overrun,
    output logic                      timeout_err
);

    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int FRM_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int PT_W  = $clog2(PASS_TIMEOUT + 1);

    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLIENTS - 1);
    localparam logic [PT_W-1:0]  PT_LAST  = PT_W'(PASS_TIMEOUT - 1);
    localparam logic [9:0]       X_LIMIT  = 10'd160;
    localparam logic [9:0]       Y_LIMIT  = 10'd120;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_E_START = 3'd1,
        ST_E_WAIT  = 3'd2,
        ST_UPD     = 3'd3,
        ST_D_START = 3'd4,
        ST_D_WAIT  = 3'd5,
        ST_NEXT    = 3'd6
    } state_t;

    state_t                   state_r, state_s;
    logic [IDX_W-1:0]         idx_r, idx_s;
    logic [FRM_W-1:0]         frame_cnt_r, frame_cnt_s;
    logic                     frame_tick_r;
    logic [PT_W-1:0]          pass_cnt_r;
    logic [7:0]               overrun_r;
    logic                     timeout_err_r;
    logic                     busy_r;
    logic [NUM_CLIENTS-1:0]   cl_start_r, cl_update_r, start_oh_s;
    logic                     cl_erase_r;
    logic [7:0]               vga_x_r;
    logic [6:0]               vga_y_r;
    logic [2:0]               vga_colour_r;
    logic                     vga_wren_r;

    logic [9:0]               act_x_s, act_y_s;
    logic [2:0]               act_colour_s;
    logic                     act_wren_s, done_s;
    logic                     in_wait_s, in_pass_s, erase_pass_s, timeout_s;

    // Frame counter next value: free-running 0..FRAME_CYCLES-1 with wrap.
    always_comb begin
        frame_cnt_s = frame_cnt_r + FRM_W'(1'b1);
        if (frame_cnt_r == FRM_LAST) begin
            frame_cnt_s = {FRM_W{1'b0}};
        end else begin
            frame_cnt_s = frame_cnt_r + FRM_W'(1'b1);
        end
    end

    // Select the active client's pixel and done signals (AND-OR mux on idx).
    always_comb begin
        act_x_s      = 10'd0;
        act_y_s      = 10'd0;
        act_colour_s = 3'd0;
        act_wren_s   = 1'b0;
        done_s       = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            act_x_s      = act_x_s      | ({10{idx_r == IDX_W'(i)}} & cl_x[10*i +: 10]);
            act_y_s      = act_y_s      | ({10{idx_r == IDX_W'(i)}} & cl_y[10*i +: 10]);
            act_colour_s = act_colour_s | ({3{idx_r == IDX_W'(i)}}  & cl_colour[3*i +: 3]);
            act_wren_s   = act_wren_s   | ((idx_r == IDX_W'(i)) & cl_wren[i]);
            done_s       = done_s       | ((idx_r == IDX_W'(i)) & cl_done[i]);
        end
    end

    // Pass classification and timeout detection for the current state.
    always_comb begin
        in_wait_s    = (state_r == ST_E_WAIT) || (state_r == ST_D_WAIT);
        erase_pass_s = (state_r == ST_E_START) || (state_r == ST_E_WAIT);
        in_pass_s    = erase_pass_s || (state_r == ST_D_START) || (state_r == ST_D_WAIT);
        timeout_s    = in_wait_s && (pass_cnt_r == PT_LAST);
    end

    // Next-state logic; done is only looked at in the wait states.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_tick_r && go) begin
                    state_s = ST_E_START;
                    idx_s   = {IDX_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_E_START: state_s = ST_E_WAIT;
            ST_E_WAIT: begin
                if (done_s || timeout_s) begin
                    state_s = ST_UPD;
                end else begin
                    state_s = ST_E_WAIT;
                end
            end
            ST_UPD:     state_s = ST_D_START;
            ST_D_START: state_s = ST_D_WAIT;
            ST_D_WAIT: begin
                if (done_s || timeout_s) begin
                    state_s = ST_NEXT;
                end else begin
                    state_s = ST_D_WAIT;
                end
            end
            ST_NEXT: begin
                if (idx_r == IDX_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_E_START;
                    idx_s   = idx_r + IDX_W'(1'b1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // One-hot of the client that will be active next cycle.
    always_comb begin
        start_oh_s = {NUM_CLIENTS{1'b0}};
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            start_oh_s[i] = (idx_s == IDX_W'(i));
        end
    end

    // State, timers, status and registered control outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            idx_r         <= {IDX_W{1'b0}};
            frame_cnt_r   <= {FRM_W{1'b0}};
            frame_tick_r  <= 1'b0;
            pass_cnt_r    <= {PT_W{1'b0}};
            overrun_r     <= 8'd0;
            timeout_err_r <= 1'b0;
            busy_r        <= 1'b0;
            cl_start_r    <= {NUM_CLIENTS{1'b0}};
            cl_update_r   <= {NUM_CLIENTS{1'b0}};
            cl_erase_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            frame_cnt_r  <= frame_cnt_s;
            frame_tick_r <= (frame_cnt_s == FRM_LAST);
            if ((state_r == ST_E_START) || (state_r == ST_D_START)) begin
                pass_cnt_r <= {PT_W{1'b0}};
            end else if (in_wait_s) begin
                pass_cnt_r <= pass_cnt_r + PT_W'(1'b1);
            end
            // A tick seen while a frame is still running is dropped.
            if (frame_tick_r && (state_r != ST_IDLE) && (overrun_r != 8'hFF)) begin
                overrun_r <= overrun_r + 8'd1;
            end
            if (timeout_s && !done_s) begin
                timeout_err_r <= 1'b1;
            end
            busy_r      <= (state_s != ST_IDLE);
            cl_start_r  <= ((state_s == ST_E_START) || (state_s == ST_D_START)) ?
                           start_oh_s : {NUM_CLIENTS{1'b0}};
            cl_update_r <= (state_s == ST_UPD) ? start_oh_s : {NUM_CLIENTS{1'b0}};
            cl_erase_r  <= (state_s == ST_E_START) || (state_s == ST_E_WAIT);
        end
    end

    // Pixel path: one-cycle registered copy of the active client, clipped.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vga_x_r      <= 8'd0;
            vga_y_r      <= 7'd0;
            vga_colour_r <= 3'd0;
            vga_wren_r   <= 1'b0;
        end else begin
            vga_x_r      <= act_x_s[7:0];
            vga_y_r      <= act_y_s[6:0];
            vga_colour_r <= erase_pass_s ? ERASE_COLOUR : act_colour_s;
            vga_wren_r   <= in_pass_s && act_wren_s &&
                            (act_x_s < X_LIMIT) && (act_y_s < Y_LIMIT);
        end
    end

    assign cl_start    = cl_start_r;
    assign cl_update   = cl_update_r;
    assign cl_erase    = cl_erase_r;
    assign vga_x       = vga_x_r;
    assign vga_y       = vga_y_r;
    assign vga_colour  = vga_colour_r;
    assign vga_wren    = vga_wren_r;
    assign frame_tick  = frame_tick_r;
    assign busy        = busy_r;
    assign overrun     = overrun_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler
// Scoreboard bench: stimulus pushes expected client events and pixels into
// queues, a negedge monitor pops and compares whenever the scheduler pulses
// cl_start/cl_update or writes a pixel. A second instance with slow clients
// exercises frame-tick overrun and its saturation.

module tb_frame_scheduler;

    localparam int NC = 2;
    localparam int FC = 100;
    localparam int PT = 16;

    typedef struct { int kind; int idx; int erase; int gap; } evt_t;
    typedef struct { int x; int y; int col; int off; } pix_t;

    logic clk = 1'b0;
    logic resetn, go, go_b;

    logic [NC-1:0]    cl_start, cl_update, cl_wren, cl_done;
    logic             cl_erase;
    logic [10*NC-1:0] cl_x, cl_y;
    logic [3*NC-1:0]  cl_colour;
    logic [7:0]       vga_x;
    logic [6:0]       vga_y;
    logic [2:0]       vga_colour;
    logic             vga_wren, frame_tick, busy, timeout_err;
    logic [7:0]       overrun;

    logic [NC-1:0]    cl_start_b, cl_update_b, cl_wren_b, cl_done_b;
    logic             cl_erase_b;
    logic [10*NC-1:0] cl_x_b, cl_y_b;
    logic [3*NC-1:0]  cl_colour_b;
    logic [7:0]       vga_x_b;
    logic [6:0]       vga_y_b;
    logic [2:0]       vga_colour_b;
    logic             vga_wren_b, frame_tick_b, busy_b, timeout_err_b;
    logic [7:0]       overrun_b;

    frame_scheduler #(.NUM_CLIENTS(NC), .FRAME_CYCLES(FC), .PASS_TIMEOUT(PT),
                      .ERASE_COLOUR(3'b000)) dut (
        .clk(clk), .resetn(resetn), .go(go),
        .cl_start(cl_start), .cl_update(cl_update), .cl_erase(cl_erase),
        .cl_x(cl_x), .cl_y(cl_y), .cl_colour(cl_colour),
        .cl_wren(cl_wren), .cl_done(cl_done),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_wren(vga_wren),
        .frame_tick(frame_tick), .busy(busy), .overrun(overrun),
        .timeout_err(timeout_err)
    );

    frame_scheduler #(.NUM_CLIENTS(NC), .FRAME_CYCLES(FC), .PASS_TIMEOUT(4096),
                      .ERASE_COLOUR(3'b000)) dut_b (
        .clk(clk), .resetn(resetn), .go(go_b),
        .cl_start(cl_start_b), .cl_update(cl_update_b), .cl_erase(cl_erase_b),
        .cl_x(cl_x_b), .cl_y(cl_y_b), .cl_colour(cl_colour_b),
        .cl_wren(cl_wren_b), .cl_done(cl_done_b),
        .vga_x(vga_x_b), .vga_y(vga_y_b), .vga_colour(vga_colour_b), .vga_wren(vga_wren_b),
        .frame_tick(frame_tick_b), .busy(busy_b), .overrun(overrun_b),
        .timeout_err(timeout_err_b)
    );

    always #5 clk = ~clk;

    int   tests_run = 0;
    int   tests_failed = 0;
    evt_t evq[$];
    pix_t pixq[$];
    int   cyc = 0;
    int   last_evt_cyc = 0;
    int   last_start_cyc = 0;
    int   evt_total = 0;

    // client configuration (dly = cycles from start to done, 0 = never)
    int   cx[NC], cy[NC], ccol[NC], cwr[NC], dly[NC];
    logic [NC-1:0] stray;
    int   cnt_a[NC], cnt_b[NC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_client(input int i, input int x, input int y, input int col,
                              input int wr, input int d);
        cx[i] = x; cy[i] = y; ccol[i] = col; cwr[i] = wr; dly[i] = d;
        cl_x[10*i +: 10]     = x[9:0];
        cl_y[10*i +: 10]     = y[9:0];
        cl_colour[3*i +: 3]  = col[2:0];
        cl_wren[i]           = wr[0];
    endtask

    task automatic push_evt(input int k, input int i, input int e, input int g);
        evt_t ev;
        ev.kind = k; ev.idx = i; ev.erase = e; ev.gap = g;
        evq.push_back(ev);
    endtask

    // pixels of one pass: start cycle plus every wait cycle, offsets 1..n
    task automatic push_pix(input int i, input int erase, input int n);
        pix_t p;
        if (cwr[i] != 0 && cx[i] < 160 && cy[i] < 120) begin
            for (int k = 1; k <= n; k++) begin
                p.x = cx[i]; p.y = cy[i]; p.col = (erase != 0) ? 0 : ccol[i]; p.off = k;
                pixq.push_back(p);
            end
        end
    endtask

    task automatic push_frame();
        int g, n;
        for (int i = 0; i < NC; i++) begin
            g = (i == 0) ? -1 : ((dly[i-1] == 0) ? PT + 2 : dly[i-1] + 2);
            n = (dly[i] == 0) ? PT + 1 : dly[i] + 1;
            push_evt(0, i, 1, g);
            push_pix(i, 1, n);
            push_evt(1, i, 0, n);
            push_evt(0, i, 0, 1);
            push_pix(i, 0, n);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((evq.size() != 0 || pixq.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check({"drain_", name}, evq.size() + pixq.size(), 0);
    endtask

    task automatic wait_tick(input string name, output int at);
        int n = 0;
        while (frame_tick !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check({"tick_", name}, frame_tick, 1);
        at = cyc;
    endtask

    // Monitor: compare every pixel write and every start/update pulse.
    always @(negedge clk) begin
        evt_t e;
        pix_t p;
        int   ak, ai;
        cyc = cyc + 1;
        if (vga_wren === 1'b1) begin
            if (pixq.size() == 0) begin
                check("pixel_expected", vga_wren, 0);
            end else begin
                p = pixq.pop_front();
                check("pix_x", vga_x, p.x);
                check("pix_y", vga_y, p.y);
                check("pix_col", vga_colour, p.col);
                check("pix_off", cyc - last_start_cyc, p.off);
            end
        end
        if (cl_start != '0 || cl_update != '0) begin
            evt_total = evt_total + 1;
            if (evq.size() == 0) begin
                check("event_expected", {cl_start, cl_update}, 0);
            end else begin
                e  = evq.pop_front();
                ak = (cl_update != '0) ? 1 : 0;
                ai = (cl_start[1] | cl_update[1]) ? 1 : 0;
                check("evt_kind", ak, e.kind);
                check("evt_idx", ai, e.idx);
                check("evt_onehot", $countones({cl_start, cl_update}), 1);
                if (e.kind == 0) check("evt_erase", cl_erase, e.erase);
                if (e.gap >= 0) check("evt_gap", cyc - last_evt_cyc, e.gap);
            end
            last_evt_cyc = cyc;
            if (cl_start != '0) last_start_cyc = cyc;
        end
    end

    // Client models: done pulse dly cycles after each start, plus stray pulses.
    initial begin
        cl_done = '0;
        cl_done_b = '0;
        for (int i = 0; i < NC; i++) begin cnt_a[i] = 0; cnt_b[i] = 0; end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NC; i++) begin
                if (!resetn) begin
                    cnt_a[i] = 0; cnt_b[i] = 0;
                    cl_done[i] = stray[i];
                    cl_done_b[i] = 1'b0;
                end else begin
                    if (cnt_a[i] > 0) begin
                        cnt_a[i]--;
                        cl_done[i] = (cnt_a[i] == 0);
                    end else begin
                        cl_done[i] = 1'b0;
                    end
                    cl_done[i] = cl_done[i] | stray[i];
                    if (cl_start[i] && dly[i] > 0) cnt_a[i] = dly[i];
                    if (cnt_b[i] > 0) begin
                        cnt_b[i]--;
                        cl_done_b[i] = (cnt_b[i] == 0);
                    end else begin
                        cl_done_b[i] = 1'b0;
                    end
                    if (cl_start_b[i]) cnt_b[i] = 150;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t1, n, prev, step_err, ev0;
        resetn = 1'b0; go = 1'b0; go_b = 1'b0; stray = '0;
        cl_x = '0; cl_y = '0; cl_colour = '0; cl_wren = '0;
        cl_x_b = '0; cl_y_b = '0; cl_colour_b = '0; cl_wren_b = '0;
        for (int i = 0; i < NC; i++) set_client(i, 0, 0, 0, 0, 5);
        repeat (3) tick();

        // reset state
        check("rst_busy", busy, 0);
        check("rst_start", cl_start, 0);
        check("rst_update", cl_update, 0);
        check("rst_erase", cl_erase, 0);
        check("rst_vga", {vga_x, vga_y, vga_colour, vga_wren}, 0);
        check("rst_overrun", overrun, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_tick", frame_tick, 0);
        resetn = 1'b1; go = 1'b1;

        // 1: ordering, busy low at each tick, frame period
        push_frame();
        wait_tick("t1a", t0);
        check("t1_busy_at_tick", busy, 0);
        tick(); tick();
        check("t1_busy_mid", busy, 1);
        drain("t1a", 200);
        push_frame();
        wait_tick("t1b", t1);
        check("t1_busy_at_tick2", busy, 0);
        check("t1_period", t1 - t0, FC);
        drain("t1b", 200);

        // 2: erase/draw pixel forwarding
        set_client(0, 32, 64, 4, 1, 5);
        push_frame();
        drain("t2", 250);

        // 3: clipping
        set_client(0, 165, 64, 4, 1, 5);
        push_frame();
        drain("t3_x165", 250);
        set_client(0, 10, 120, 4, 1, 5);
        push_frame();
        drain("t3_y120", 250);
        set_client(0, 159, 119, 2, 1, 5);
        push_frame();
        drain("t3_edge", 250);

        // 4: pass timeout on client 1
        set_client(0, 0, 0, 0, 0, 5);
        check("t4_terr_before", timeout_err, 0);
        set_client(1, 0, 0, 0, 0, 0);
        push_frame();
        drain("t4a", 300);
        check("t4_terr_set", timeout_err, 1);
        set_client(1, 0, 0, 0, 0, 5);
        push_frame();
        drain("t4b", 300);
        check("t4_terr_sticky", timeout_err, 1);

        // 6: reset during D_WAIT of client 0
        set_client(0, 32, 64, 4, 1, 5);
        push_evt(0, 0, 1, -1);
        push_pix(0, 1, 6);
        push_evt(1, 0, 0, 6);
        push_evt(0, 0, 0, 1);
        push_pix(0, 0, 1);
        n = 0;
        while (evq.size() != 0 && n < 250) begin tick(); n++; end
        check("t6_reach_dstart", evq.size(), 0);
        tick();
        resetn = 1'b0;
        tick();
        check("t6_busy", busy, 0);
        check("t6_cl", {cl_start, cl_update, cl_erase}, 0);
        check("t6_vga", {vga_x, vga_y, vga_colour, vga_wren}, 0);
        check("t6_terr", timeout_err, 0);
        check("t6_pix_left", pixq.size(), 0);
        resetn = 1'b1;
        repeat (5) tick();
        stray = 2'b11;
        tick();
        stray = 2'b00;
        tick(); tick();
        check("t6_stray_busy", busy, 0);
        check("t6_stray_start", cl_start, 0);
        push_frame();
        drain("t6_clean", 300);

        // go low mid-frame: current frame completes, no new frame
        set_client(0, 0, 0, 0, 0, 5);
        push_frame();
        n = 0;
        while (evq.size() > 5 && n < 200) begin tick(); n++; end
        go = 1'b0;
        drain("golow", 200);
        ev0 = evt_total;
        repeat (250) tick();
        check("golow_no_events", evt_total - ev0, 0);
        check("golow_busy", busy, 0);
        check("a_overrun", overrun, 0);

        // 5: overrun counting and saturation on the slow instance
        go_b = 1'b1;
        n = 0;
        while (overrun_b == 8'd0 && n < 2000) begin tick(); n++; end
        check("t5_first_drop", overrun_b, 1);
        prev = overrun_b;
        step_err = 0;
        n = 0;
        while (overrun_b != 8'd255 && n < 40000) begin
            tick();
            n++;
            if (overrun_b != prev[7:0] && overrun_b != prev[7:0] + 8'd1) step_err++;
            prev = overrun_b;
        end
        check("t5_reach_255", overrun_b, 255);
        check("t5_steps", step_err, 0);
        repeat (800) tick();
        check("t5_saturated", overrun_b, 255);
        check("t5_no_timeout", timeout_err_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
